// File: rtl/sat_addsub_pipe_pkg.sv
// Shared definitions for the saturating add/sub pipeline: op encoding,
// default geometry and pipeline depth.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_PADD = 2'b10,
    OP_PSUB = 2'b11
  } op_e;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_LANE_W = 4;
  localparam int STAGES     = 2;

endpackage

// File: rtl/sat_addsub_pipe_lane.sv
// One saturating signed add/sub of width W. The sum is formed one bit wider
// so overflow is simply the top two bits disagreeing; the extra bit then
// tells which rail to clamp to.
module sat_add_lane #(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] s,
  output logic         ovf
);

  logic [W:0] w_xe;
  logic [W:0] w_ye;
  logic [W:0] w_sum;

  assign w_xe  = {x[W-1], x};
  assign w_ye  = {y[W-1], y};
  assign w_sum = sub ? (w_xe - w_ye) : (w_xe + w_ye);
  assign ovf   = w_sum[W] ^ w_sum[W-1];

  // Clamp to the rail on the side the true sum went out of range.
  always_comb begin
    s = w_sum[W-1:0];
    if (ovf) s = w_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

endmodule

// File: rtl/sat_addsub_pipe.sv
// Two-stage saturating add/sub with valid/ready flow control.
// Stage 1 holds operands/op, stage 2 holds the saturated result and flags.
// Define SAT_ADDSUB_LANE_MODE_EN to build packed-lane PADD/PSUB; without it
// op[1] is ignored and only the full-width adder exists.
module sat_addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LANE_W = DEF_LANE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  input  logic             clr_cnt,
  output logic [7:0]       sat_cnt
);

  if ((WIDTH % LANE_W) != 0) begin : g_cfg_err
    $error("WIDTH must be a multiple of LANE_W");
  end

  logic [STAGES:1]  r_vld_pipe;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  op_e              r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_z;
  logic             r_n;
  logic             r_v;
  logic [7:0]       r_sat_cnt;

  logic             w_adv1;
  logic             w_acc;
  logic             w_deliver;
  logic             w_sub;
  logic [WIDTH-1:0] w_full_s;
  logic             w_full_ovf;
  logic [WIDTH-1:0] w_res;
  logic             w_v;

  assign w_adv1    = !r_vld_pipe[2] || out_ready;
  assign in_ready  = !r_vld_pipe[1] || w_adv1;
  assign w_acc     = in_valid && in_ready;
  assign w_deliver = r_vld_pipe[2] && out_ready;
  assign w_sub     = (r_op == OP_SUB) || (r_op == OP_PSUB);

  sat_add_lane #(.W(WIDTH)) u_full (
    .x   (r_a),
    .y   (r_b),
    .sub (w_sub),
    .s   (w_full_s),
    .ovf (w_full_ovf)
  );

`ifdef SAT_ADDSUB_LANE_MODE_EN
  localparam int NUM_LANES = WIDTH / LANE_W;

  logic [NUM_LANES-1:0][LANE_W-1:0] w_lane_s;
  logic [NUM_LANES-1:0]             w_lane_ovf;
  logic                             w_lane;

  assign w_lane = (r_op == OP_PADD) || (r_op == OP_PSUB);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    sat_add_lane #(.W(LANE_W)) u_lane (
      .x   (r_a[g*LANE_W +: LANE_W]),
      .y   (r_b[g*LANE_W +: LANE_W]),
      .sub (w_sub),
      .s   (w_lane_s[g]),
      .ovf (w_lane_ovf[g])
    );
  end

  // Pick packed-lane or full-width result for the stage-2 register.
  always_comb begin
    w_res = w_full_s;
    w_v   = w_full_ovf;
    if (w_lane) begin
      w_res = w_lane_s;
      w_v   = |w_lane_ovf;
    end
  end
`else
  assign w_res = w_full_s;
  assign w_v   = w_full_ovf;
`endif

  // Stage 1: capture operands on accept; empties when it hands off downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe[1] <= 1'b0;
      r_a           <= '0;
      r_b           <= '0;
      r_op          <= OP_ADD;
    end else begin
      if (w_acc) begin
        r_a  <= a;
        r_b  <= b;
        r_op <= op_e'(op);
      end
      if (w_acc)       r_vld_pipe[1] <= 1'b1;
      else if (w_adv1) r_vld_pipe[1] <= 1'b0;
    end
  end

  // Stage 2: result and flags load together and hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe[2] <= 1'b0;
      r_result      <= '0;
      r_z           <= 1'b0;
      r_n           <= 1'b0;
      r_v           <= 1'b0;
    end else if (w_adv1) begin
      r_vld_pipe[2] <= r_vld_pipe[1];
      if (r_vld_pipe[1]) begin
        r_result <= w_res;
        r_z      <= (w_res == '0);
        r_n      <= w_res[WIDTH-1];
        r_v      <= w_v;
      end
    end
  end

  // Saturation counter: counts delivered saturated results, sticks at 255,
  // and a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        r_sat_cnt <= '0;
    else if (clr_cnt)                                  r_sat_cnt <= '0;
    else if (w_deliver && r_v && (r_sat_cnt != 8'hFF)) r_sat_cnt <= r_sat_cnt + 8'd1;
  end

  assign out_valid = r_vld_pipe[2];
  assign result    = r_result;
  assign flag_z    = r_z;
  assign flag_n    = r_n;
  assign flag_v    = r_v;
  assign sat_cnt   = r_sat_cnt;

endmodule

// File: tb/tb_sat_addsub_pipe.sv
// Scoreboard bench for sat_addsub_pipe. Expected results come from an
// integer reference model and are queued at acceptance; a negedge monitor
// pops and compares on every delivered result.
module tb_sat_addsub_pipe;

  localparam int W  = 16;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [1:0]    op = 2'b00;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  result;
  logic          flag_z, flag_n, flag_v;
  logic          clr_cnt = 1'b0;
  logic [7:0]    sat_cnt;

  typedef struct {
    logic [W-1:0] r;
    logic         z;
    logic         n;
    logic         v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   n_deliv = 0;

  sat_addsub_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
    .clr_cnt(clr_cnt), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  function automatic void sat_op(input longint x, input longint y, input bit sub,
                                 input int w, output longint r, output bit v);
    longint s, mx, mn;
    s  = sub ? (x - y) : (x + y);
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -mx - 1;
    v  = 1'b0;
    if (s > mx)      begin r = mx; v = 1'b1; end
    else if (s < mn) begin r = mn; v = 1'b1; end
    else             r = s;
  endfunction

  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                 input logic [1:0] top);
    exp_t   e;
    longint r;
    bit     v;
    e.r = '0;
    e.v = 1'b0;
`ifdef SAT_ADDSUB_LANE_MODE_EN
    if (top[1]) begin
      for (int l = 0; l < W / LW; l++) begin
        logic [LW-1:0] la, lb;
        la = ta[l*LW +: LW];
        lb = tb_[l*LW +: LW];
        sat_op(longint'($signed(la)), longint'($signed(lb)), top[0], LW, r, v);
        e.r[l*LW +: LW] = r[LW-1:0];
        e.v = e.v | v;
      end
    end else
`endif
    begin
      sat_op(longint'($signed(ta)), longint'($signed(tb_)), top[0], W, r, v);
      e.r = r[W-1:0];
      e.v = v;
    end
    e.z = (e.r == '0);
    e.n = e.r[W-1];
    return e;
  endfunction

  // Scoreboard monitor: every handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output got result=%h with empty scoreboard", result);
      end else begin
        exp_t e;
        e = q.pop_front();
        n_deliv++;
        if ({result, flag_z, flag_n, flag_v} !== {e.r, e.z, e.n, e.v}) begin
          failures++;
          $display("FAIL scoreboard got r=%h z%b n%b v%b want r=%h z%b n%b v%b",
                   result, flag_z, flag_n, flag_v, e.r, e.z, e.n, e.v);
        end
      end
    end
  end

  // Present one op and hold until accepted; in_valid is left high.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [1:0] top);
    bit ok = 1'b0;
    a = ta; b = tb_; op = top; in_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(model(ta, tb_, top));
        ok = 1'b1;
      end
    end
    @(posedge clk); #1;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d want 0", name, q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready, result, flag_z, flag_n, flag_v, sat_cnt} !==
        {1'b0, 1'b1, {W{1'b0}}, 3'b000, 8'd0}) begin
      failures++;
      $display("FAIL reset_state got ov=%b ir=%b r=%h f=%b%b%b cnt=%0d want 0,1,0,000,0",
               out_valid, in_ready, result, flag_z, flag_n, flag_v, sat_cnt);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_sub();
    out_ready = 1'b1;
    send(16'd20000, 16'd10000, 2'b00);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_early out_valid=%b want 0", out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, result, flag_z, flag_n, flag_v} !== {1'b1, 16'd30000, 3'b000}) begin
      failures++;
      $display("FAIL add_latency2 got ov=%b r=%0d f=%b%b%b want 1 30000 000",
               out_valid, result, flag_z, flag_n, flag_v);
    end
    send(16'd20000, 16'd10000, 2'b01);
    send(16'd100, 16'd100, 2'b01);
    in_valid = 1'b0;
    wait_drain("add_sub");
  endtask

  task automatic test_saturate();
    send(16'h7FFF, 16'd100, 2'b00);
    send(-16'sd32767, -16'sd1234, 2'b00);
    in_valid = 1'b0;
    wait_drain("saturate");
    checks++;
    if (sat_cnt !== 8'd2) begin
      failures++;
      $display("FAIL sat_cnt_two got %0d want 2", sat_cnt);
    end
  endtask

  task automatic test_lanes();
    send(16'h7712, 16'h1111, 2'b10);
    send(16'h8000, 16'h1000, 2'b11);
    send(16'h1234, 16'h4321, 2'b10);
    send(16'h0F0F, 16'h1919, 2'b11);
    in_valid = 1'b0;
    wait_drain("lanes");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] held_r;
    logic [2:0]   held_f;
    bit           have_held = 1'b0;
    bit           saw_not_ready = 1'b0;
    int           d0 = n_deliv;
    out_ready = 1'b1;
    fork
      begin
        send(16'd1, 16'd2, 2'b00);
        send(16'h7000, 16'h2000, 2'b00);
        send(16'd5, 16'd9, 2'b01);
        send(16'h8001, 16'h0005, 2'b01);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          if (!in_ready) saw_not_ready = 1'b1;
          if (out_valid && !have_held) begin
            held_r = result; held_f = {flag_z, flag_n, flag_v}; have_held = 1'b1;
          end else if (have_held) begin
            checks++;
            if ({out_valid, result, flag_z, flag_n, flag_v} !== {1'b1, held_r, held_f}) begin
              failures++;
              $display("FAIL stall_hold got ov=%b r=%h want 1 r=%h", out_valid, result, held_r);
            end
          end
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    wait_drain("b2b");
    checks++;
    if (!saw_not_ready) begin
      failures++;
      $display("FAIL stall_in_ready in_ready stayed 1 want 0 during stall");
    end
    checks++;
    if (n_deliv - d0 != 4) begin
      failures++;
      $display("FAIL b2b_count got %0d want 4", n_deliv - d0);
    end
  endtask

  task automatic test_random();
    bit done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [W-1:0] ra, rb;
          logic [1:0]   ro;
          ra = W'($urandom); rb = W'($urandom); ro = 2'($urandom_range(0, 3));
          send(ra, rb, ro);
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
          end
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain("random");
  endtask

  task automatic test_sticky();
    out_ready = 1'b1;
    for (int i = 0; i < 260; i++) send(16'h7FFF, 16'h0001, 2'b00);
    in_valid = 1'b0;
    wait_drain("sticky");
    checks++;
    if (sat_cnt !== 8'd255) begin
      failures++;
      $display("FAIL sat_cnt_sticky got %0d want 255", sat_cnt);
    end
  endtask

  task automatic test_clr_priority();
    int n = 0;
    out_ready = 1'b0;
    send(16'h8000, 16'h0001, 2'b01);
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    clr_cnt = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    checks++;
    if (sat_cnt !== 8'd0 || q.size() != 0) begin
      failures++;
      $display("FAIL clr_priority got cnt=%0d pending=%0d want 0 0", sat_cnt, q.size());
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    send(16'h7FFF, 16'h0100, 2'b00);
    send(16'd3, 16'd4, 2'b00);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, sat_cnt, result} !== {1'b0, 1'b1, 8'd0, {W{1'b0}}}) begin
      failures++;
      $display("FAIL reset_midflight got ov=%b ir=%b cnt=%0d r=%h want 0 1 0 0",
               out_valid, in_ready, sat_cnt, result);
    end
    q.delete();
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL stale_after_reset cycle=%0d out_valid=%b want 0", c, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_saturate();
    test_lanes();
    test_back_to_back();
    test_random();
    test_sticky();
    test_clr_priority();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout sim time exceeded");
    $fatal(1);
  end

endmodule
